dsp_write_mailbox: RTL and testbench

//  Write-direction counterpart of the DSP-read app blocks. The DSP writes 16-bit words over the

---
 rtl/dsp_write_mailbox.sv | 120 ++++++++++++
 tb/tb_dsp_write_mailbox.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dsp_write_mailbox.sv
// DSP-to-FPGA write mailbox: the DSP pushes 16-bit words into a FWFT FIFO over the address/data bus,
// and the FPGA side drains them through a valid/ready handshake. Status is readable over the same bus.
module dsp_write_mailbox #(
  parameter logic [7:0]  offset_to_add_to_ab = 8'h00,
  parameter logic [7:0]  ADDR_MBX_DATA       = 8'h40,
  parameter logic [7:0]  ADDR_MBX_CTRL       = 8'h41,
  parameter logic [7:0]  ADDR_MBX_STATUS     = 8'h42,
  parameter int unsigned DEPTH_LOG2          = 4
) (
  input  logic                  xclk,
  input  logic                  reset,
  input  logic                  write_qualified,
  input  logic                  read_qualified,
  input  logic [7:0]            ab,
  input  logic [15:0]           db_in,
  output logic [15:0]           db_out_mbx,
  output logic                  data_from_mbx_avail,
  output logic [15:0]           mbx_data,
  output logic                  mbx_valid,
  input  logic                  mbx_ready,
  output logic [DEPTH_LOG2:0]   mbx_level
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PAD   = 16 - 3 - LW;

  localparam logic [7:0] A_DATA   = 8'(ADDR_MBX_DATA + offset_to_add_to_ab);
  localparam logic [7:0] A_CTRL   = 8'(ADDR_MBX_CTRL + offset_to_add_to_ab);
  localparam logic [7:0] A_STATUS = 8'(ADDR_MBX_STATUS + offset_to_add_to_ab);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [LW-1:0] level_n;
  logic          wq_d, overflow, overflow_n;
  logic          wr_ev, data_wr, flush, clr_ovf, full, empty, push, pop;
  logic [15:0]   head_n;

  // Decode the single write event per strobe and compute next FIFO state
  always_comb begin
    wr_ev      = write_qualified & ~wq_d;
    data_wr    = wr_ev && (ab == A_DATA);
    flush      = wr_ev && (ab == A_CTRL) && db_in[0];
    clr_ovf    = wr_ev && (ab == A_CTRL) && db_in[1];
    full       = (mbx_level == LW'(DEPTH));
    empty      = (mbx_level == '0);
    pop        = mbx_valid & mbx_ready & ~flush;
    // A pop in the same cycle frees a slot, so a push while full is still accepted
    push       = data_wr & (~full | pop);
    overflow_n = overflow;
    if (data_wr && full && !pop)
      overflow_n = 1'b1;
    if (clr_ovf)
      overflow_n = 1'b0;

    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    level_n  = mbx_level;
    if (flush) begin
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      level_n  = '0;
    end else begin
      if (pop)
        rd_ptr_n = rd_ptr + AW'(1);
      if (push)
        wr_ptr_n = wr_ptr + AW'(1);
      if (push && !pop)
        level_n = mbx_level + LW'(1);
      else if (pop && !push)
        level_n = mbx_level - LW'(1);
    end

    // Bypass the incoming word when it lands exactly at the new head
    head_n = (push && (wr_ptr == rd_ptr_n)) ? db_in : mem[rd_ptr_n];
  end

  always_ff @(posedge xclk) begin
    if (push)
      mem[wr_ptr] <= db_in;
  end

  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      wq_d      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mbx_level <= '0;
      mbx_valid <= 1'b0;
      mbx_data  <= 16'h0000;
      overflow  <= 1'b0;
    end else begin
      wq_d      <= write_qualified;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      mbx_level <= level_n;
      mbx_valid <= (level_n != '0);
      mbx_data  <= head_n;
      overflow  <= overflow_n;
    end
  end

  // Bus read path: holds its last value while no read is in progress
  always_ff @(posedge xclk or negedge reset) begin
    if (!reset) begin
      db_out_mbx          <= 16'h0000;
      data_from_mbx_avail <= 1'b0;
    end else if (read_qualified) begin
      if (ab == A_STATUS) begin
        db_out_mbx          <= {overflow, full, empty, {PAD{1'b0}}, mbx_level};
        data_from_mbx_avail <= 1'b1;
      end else begin
        db_out_mbx          <= 16'hFFFF;
        data_from_mbx_avail <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dsp_write_mailbox.sv
// Bench for dsp_write_mailbox: a queue-based mailbox model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dsp_write_mailbox;

  logic        xclk = 1'b0;
  logic        reset = 1'b0;
  logic        wq = 1'b0, rq = 1'b0, ready = 1'b0;
  logic [7:0]  ab = 8'h00;
  logic [15:0] db = 16'h0000;
  logic [15:0] db_out_mbx, mbx_data;
  logic        data_from_mbx_avail, mbx_valid;
  logic [4:0]  mbx_level;

  dsp_write_mailbox dut (
    .xclk(xclk), .reset(reset), .write_qualified(wq), .read_qualified(rq),
    .ab(ab), .db_in(db), .db_out_mbx(db_out_mbx),
    .data_from_mbx_avail(data_from_mbx_avail), .mbx_data(mbx_data),
    .mbx_valid(mbx_valid), .mbx_ready(ready), .mbx_level(mbx_level)
  );

  always #5 xclk = ~xclk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: inputs are stable at the negedge, equal to those seen at the preceding posedge
  logic [15:0] q[$];
  logic        m_ovf = 1'b0, m_wqd = 1'b0, m_avail = 1'b0, ev;
  logic [15:0] m_dbo = 16'h0000, last_pop = 16'h0000;
  int          sz;

  always @(negedge xclk) begin
    if (!reset) begin
      q.delete();
      m_ovf = 1'b0; m_wqd = 1'b0; m_dbo = 16'h0000; m_avail = 1'b0;
    end else begin
      sz = q.size();
      ev = wq && !m_wqd;
      m_wqd = wq;
      if (rq) begin
        if (ab == 8'h42) begin
          m_dbo = {m_ovf, sz == 16, sz == 0, 8'h00, 5'(sz)};
          m_avail = 1'b1;
        end else begin
          m_dbo = 16'hFFFF;
          m_avail = 1'b0;
        end
      end
      if (ev && ab == 8'h41 && db[0])
        q.delete();
      else if (ready && sz > 0)
        last_pop = q.pop_front();
      if (ev && ab == 8'h40) begin
        if (q.size() < 16) q.push_back(db);
        else m_ovf = 1'b1;
      end
      if (ev && ab == 8'h41 && db[1])
        m_ovf = 1'b0;
    end
    check("level", 32'(mbx_level), 32'(q.size()));
    check("valid", 32'(mbx_valid), 32'(q.size() > 0));
    if (q.size() > 0)
      check("head", 32'(mbx_data), 32'(q[0]));
    check("db_out", 32'(db_out_mbx), 32'(m_dbo));
    check("avail", 32'(data_from_mbx_avail), 32'(m_avail));
  end

  task automatic tick();
    @(negedge xclk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
    ab = a; db = d; wq = 1'b1;
    tick();
    wq = 1'b0;
    tick();
  endtask

  task automatic status_read(input logic [15:0] exp, input string name);
    ab = 8'h42; rq = 1'b1;
    tick();
    rq = 1'b0;
    check(name, 32'(db_out_mbx), 32'(exp));
    check({name, "_avail"}, 32'(data_from_mbx_avail), 32'd1);
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int i = 0; i < 40 && mbx_valid; i++) tick();
    check("drain_done", 32'(mbx_valid), 32'd0);
    ready = 1'b0;
    tick();
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_dbo"}, 32'(db_out_mbx), 32'h0);
    check({name, "_avail"}, 32'(data_from_mbx_avail), 32'd0);
    check({name, "_valid"}, 32'(mbx_valid), 32'd0);
    check({name, "_level"}, 32'(mbx_level), 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    check_reset_values("reset");
    reset = 1'b1;
    tick();

    // Three pushes with the consumer stalled
    bus_write(8'h40, 16'h1111);
    bus_write(8'h40, 16'h2222);
    bus_write(8'h40, 16'h3333);
    check("t1_level", 32'(mbx_level), 32'd3);
    check("t1_head", 32'(mbx_data), 32'h1111);
    status_read(16'h0003, "t1_status");
    drain();

    // A long strobe produces exactly one push
    ab = 8'h40; db = 16'hABCD; wq = 1'b1;
    repeat (5) tick();
    wq = 1'b0;
    tick();
    check("t2_level", 32'(mbx_level), 32'd1);
    check("t2_head", 32'(mbx_data), 32'hABCD);
    drain();

    // Overfill by one, then clear the sticky overflow
    for (int i = 0; i < 17; i++) bus_write(8'h40, 16'(i));
    check("t3_level", 32'(mbx_level), 32'd16);
    status_read(16'hC010, "t3_status_ovf");
    bus_write(8'h41, 16'h0002);
    status_read(16'h4010, "t3_status_clr");

    // Push while full, accepted because a pop happens in the same cycle
    ab = 8'h40; db = 16'h5A5A; wq = 1'b1; ready = 1'b1;
    tick();
    wq = 1'b0;
    check("t4_level_held", 32'(mbx_level), 32'd16);
    drain();
    check("t4_last_pop", 32'(last_pop), 32'h5A5A);
    status_read(16'h2000, "t4_status");

    // Flush wins over a concurrent pop
    for (int i = 0; i < 5; i++) bus_write(8'h40, 16'h0100 + 16'(i));
    check("t5_level", 32'(mbx_level), 32'd5);
    ab = 8'h41; db = 16'h0001; wq = 1'b1; ready = 1'b1;
    tick();
    wq = 1'b0; ready = 1'b0;
    check("t5_level_flushed", 32'(mbx_level), 32'd0);
    check("t5_valid_flushed", 32'(mbx_valid), 32'd0);
    check("t5_last_pop", 32'(last_pop), 32'h5A5A);
    tick();
    bus_write(8'h40, 16'h7777);
    check("t5_refill_head", 32'(mbx_data), 32'h7777);
    drain();

    // Unmapped read, then reset in the middle of activity
    ab = 8'h7F; rq = 1'b1;
    tick();
    rq = 1'b0;
    check("t6_unmapped", 32'(db_out_mbx), 32'hFFFF);
    check("t6_unmapped_avail", 32'(data_from_mbx_avail), 32'd0);
    bus_write(8'h40, 16'hBEEF);
    bus_write(8'h40, 16'hCAFE);
    status_read(16'h0002, "t6_status");
    reset = 1'b0;
    tick();
    check_reset_values("t6_midreset");
    reset = 1'b1;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
